// File: rtl/uart_tx.sv
// uart_tx: transmit half of the UART peripheral.
// Bus writes to tx_reg queue characters in a small FIFO; the FSM serialises
// them LSB-first onto txout with 16 baud ticks per bit.
// Build macro UART_TX_PARITY_EN adds an even parity bit after D7 (11-bit frame)
// and sets control bit4 as a capability flag.
module uart_tx #(
  parameter logic [7:0] PERIOD     = 8'h1A,
  parameter int         DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wren,
  input  logic       rden,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  output logic [8:0] dout,
  output logic       txout
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

`ifdef UART_TX_PARITY_EN
  localparam int   FRAME_BITS = 11;
  localparam logic CAP_PARITY = 1'b1;
`else
  localparam int   FRAME_BITS = 10;
  localparam logic CAP_PARITY = 1'b0;
`endif

  localparam logic [3:0]            LAST_BIT  = 4'(FRAME_BITS - 1);
  localparam logic [DEPTH_LOG2:0]   FULL_CNT  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  localparam logic [2:0] ADDR_PERIOD = 3'b100;
  localparam logic [2:0] ADDR_TX     = 3'b110;
  localparam logic [2:0] ADDR_CTRL   = 3'b111;

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             period_q, period_d;
  logic                   txen_q, txen_d;
  logic                   overrun_q, overrun_d;
  logic [7:0]             baud_q, baud_d;
  logic [3:0]             tick_cnt_q, tick_cnt_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic                   txout_q, txout_d;
  logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]    count_q, count_d;
  logic [7:0]             mem_q [DEPTH];

  logic       full, empty, busy;
  logic       tx_write, push, pop, drop;
  logic       period_wr, tick;
  logic [7:0] head;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign busy      = (state_q != IDLE) | ~empty;
  assign tx_write  = wren & (addr == ADDR_TX);
  assign push      = tx_write & ~full;
  assign drop      = tx_write & full;
  assign pop       = (state_q == LOAD);
  assign period_wr = wren & (addr == ADDR_PERIOD);
  assign tick      = (state_q == SEND) & (baud_q == period_q);
  assign head      = mem_q[rd_ptr_q];
  assign txout     = txout_q;

  // Register writes; a dropped push raises OVERRUN for at least one cycle so it
  // is visible on the next read, after which a disabled transmitter clears it.
  always_comb begin
    period_d  = period_q;
    txen_d    = txen_q;
    overrun_d = overrun_q;
    if (period_wr) period_d = din;
    if (wren && addr == ADDR_CTRL) txen_d = din[0];
    if (drop) overrun_d = 1'b1;
    else if (!txen_q) overrun_d = 1'b0;
  end

  // FIFO pointer and occupancy update; push and pop may coincide.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Baud counter runs only while sending and restarts on a period write.
  always_comb begin
    baud_d = baud_q + 8'd1;
    if (state_q != SEND || period_wr || tick) baud_d = 8'd0;
  end

  // Frame FSM: next state, shift register, tick/bit counters and txout.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    txout_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (txen_q && !empty) state_d = LOAD;
      end
      LOAD: begin
`ifdef UART_TX_PARITY_EN
        shift_d = {1'b1, ^head, head, 1'b0};
`else
        shift_d = {1'b1, head, 1'b0};
`endif
        tick_cnt_d = 4'd0;
        bit_cnt_d  = 4'd0;
        state_d    = SEND;
      end
      SEND: begin
        txout_d = shift_q[0];
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            shift_d   = {1'b1, shift_q[FRAME_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == LAST_BIT) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read mux: combinational, zero unless a mapped register is being read.
  always_comb begin
    dout = 9'd0;
    if (rden) begin
      case (addr)
        ADDR_PERIOD: dout = {1'b0, period_q};
        ADDR_CTRL:   dout = {4'b0000, CAP_PARITY, busy, overrun_q, ~full, txen_q};
        default:     dout = 9'd0;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      period_q   <= PERIOD;
      txen_q     <= 1'b0;
      overrun_q  <= 1'b0;
      baud_q     <= 8'd0;
      tick_cnt_q <= 4'd0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= '1;
      txout_q    <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      txen_q     <= txen_d;
      overrun_q  <= overrun_d;
      baud_q     <= baud_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      txout_q    <= txout_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx. Bytes expected on the line are
// queued when written; a serial monitor pops and compares each received frame.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam logic [2:0] A_PERIOD = 3'b100;
  localparam logic [2:0] A_TX     = 3'b110;
  localparam logic [2:0] A_CTRL   = 3'b111;

`ifdef UART_TX_PARITY_EN
  localparam logic [8:0] CAP   = 9'h010;
  localparam int         FRAME = 11;
`else
  localparam logic [8:0] CAP   = 9'h000;
  localparam int         FRAME = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wren = 1'b0;
  logic       rden = 1'b0;
  logic [2:0] addr = 3'b000;
  logic [7:0] din = 8'h00;
  logic [8:0] dout;
  logic       txout;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int bit_clks = 432;
  bit rx_on = 1'b1;
  int rx_count = 0;
  logic [7:0] sb [$];
  int starts [$];

  uart_tx dut (
    .clk   (clk),
    .reset (reset),
    .wren  (wren),
    .rden  (rden),
    .addr  (addr),
    .din   (din),
    .dout  (dout),
    .txout (txout)
  );

  always #5 clk = ~clk;

  // Count rising edges so latencies can be measured in clocks.
  always @(posedge clk) cyc <= cyc + 1;

  // Serial monitor: detect start bit, sample mid-bit, compare with scoreboard.
  always begin
    logic [7:0] data;
    logic       stop;
    logic       par;
    logic [7:0] exp;
    int         bc;
    @(negedge clk);
    if (rx_on && reset && txout === 1'b0) begin
      bc = bit_clks;
      starts.push_back(cyc);
      par = 1'b0;
      repeat (bc / 2) @(negedge clk);
      vectors++;
      if (txout !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rx_start_bit: got %b want 0", txout);
      end
      for (int i = 0; i < 8; i++) begin
        repeat (bc) @(negedge clk);
        data[i] = txout;
      end
`ifdef UART_TX_PARITY_EN
      repeat (bc) @(negedge clk);
      par = txout;
`endif
      repeat (bc) @(negedge clk);
      stop = txout;
      rx_count++;
      vectors++;
      if (stop !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL rx_stop_bit: got %b want 1", stop);
      end
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL rx_unexpected: got %h want no frame", data);
      end else begin
        exp = sb.pop_front();
        if (data !== exp) begin
          miscompares++;
          $display("[TB] FAIL rx_data: got %h want %h", data, exp);
        end
`ifdef UART_TX_PARITY_EN
        vectors++;
        if (par !== ^exp) begin
          miscompares++;
          $display("[TB] FAIL rx_parity: got %b want %b", par, ^exp);
        end
`endif
      end
    end
  end

  // Bus helpers: called at a negedge, return at a negedge.
  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    wren = 1'b1; addr = a; din = d;
    @(negedge clk);
    wren = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [8:0] d);
    rden = 1'b1; addr = a;
    #1;
    d = dout;
    rden = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_level(input logic lvl, input int limit, output int at, output bit ok);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < limit; i++) begin
      if (txout === lvl) begin
        at = cyc;
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && sb.size() != 0; i++) @(negedge clk);
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [8:0] d;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (txout !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_txout: got %b want 1", txout);
    end
    reset = 1'b1;
    @(negedge clk);
    // TXRDY is ~full, so an empty FIFO reads it as 1.
    bus_read(A_CTRL, d);
    vectors++;
    if (d !== (9'h002 | CAP)) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %h want %h", d, 9'h002 | CAP);
    end
    bus_read(A_PERIOD, d);
    vectors++;
    if (d !== 9'h01A) begin
      miscompares++;
      $display("[TB] FAIL reset_period: got %h want 01a", d);
    end
    bus_read(A_TX, d);
    vectors++;
    if (d !== 9'h000) begin
      miscompares++;
      $display("[TB] FAIL read_txreg: got %h want 000", d);
    end
    bus_read(3'b001, d);
    vectors++;
    if (d !== 9'h000) begin
      miscompares++;
      $display("[TB] FAIL read_unmapped: got %h want 000", d);
    end
    addr = A_PERIOD;
    #1;
    vectors++;
    if (dout !== 9'h000) begin
      miscompares++;
      $display("[TB] FAIL dout_no_rden: got %h want 000", dout);
    end
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    logic [8:0] d;
    int wcyc, f, r, n;
    bit ok;
    n = rx_count;
    bus_write(A_CTRL, 8'h01);
    sb.push_back(8'hA5);
    bus_write(A_TX, 8'hA5);
    wcyc = cyc;
    wait_level(1'b0, 50, f, ok);
    vectors++;
    if (!ok || f - wcyc != 3) begin
      miscompares++;
      $display("[TB] FAIL start_latency: got %0d (seen=%0d) want 3", f - wcyc, ok);
    end
    wait_level(1'b1, 1000, r, ok);
    vectors++;
    if (!ok || r - f != 432) begin
      miscompares++;
      $display("[TB] FAIL bit_time: got %0d (seen=%0d) want 432", r - f, ok);
    end
    bus_read(A_CTRL, d);
    vectors++;
    if (d !== (9'h00B | CAP)) begin
      miscompares++;
      $display("[TB] FAIL busy_in_frame: got %h want %h", d, 9'h00B | CAP);
    end
    while (cyc < f + FRAME * 432 + 4) @(negedge clk);
    bus_read(A_CTRL, d);
    vectors++;
    if (d !== (9'h003 | CAP)) begin
      miscompares++;
      $display("[TB] FAIL idle_after_frame: got %h want %h", d, 9'h003 | CAP);
    end
    vectors++;
    if (rx_count - n != 1 || sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL single_frame_count: got %0d frames, %0d pending want 1, 0", rx_count - n, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] d;
    int n0;
    bus_write(A_PERIOD, 8'h00);
    bit_clks = 16;
    bus_read(A_PERIOD, d);
    vectors++;
    if (d !== 9'h000) begin
      miscompares++;
      $display("[TB] FAIL period_write: got %h want 000", d);
    end
    n0 = starts.size();
    sb.push_back(8'h3C);
    sb.push_back(8'hC3);
    bus_write(A_TX, 8'h3C);
    bus_write(A_TX, 8'hC3);
    for (int i = 0; i < 1000 && starts.size() < n0 + 2; i++) @(negedge clk);
    vectors++;
    if (starts.size() != n0 + 2) begin
      miscompares++;
      $display("[TB] FAIL b2b_frames: got %0d starts want 2", starts.size() - n0);
    end else if (starts[n0 + 1] - starts[n0] != FRAME * 16 + 2) begin
      miscompares++;
      $display("[TB] FAIL b2b_spacing: got %0d want %0d", starts[n0 + 1] - starts[n0], FRAME * 16 + 2);
    end
    wait_drain(1000);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL b2b_drain: got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_overrun();
    logic [8:0] d;
    logic [7:0] b;
    int n;
    bus_write(A_CTRL, 8'h00);
    for (int i = 0; i < 9; i++) begin
      b = (i == 8) ? 8'hEE : 8'h10 + 8'(i);
      if (i < 8) sb.push_back(b);
      bus_write(A_TX, b);
      if (i == 7) begin
        bus_read(A_CTRL, d);
        vectors++;
        if (d !== (9'h008 | CAP)) begin
          miscompares++;
          $display("[TB] FAIL fifo_full: got %h want %h", d, 9'h008 | CAP);
        end
      end
      if (i == 8) begin
        bus_read(A_CTRL, d);
        vectors++;
        if (d !== (9'h00C | CAP)) begin
          miscompares++;
          $display("[TB] FAIL overrun_set: got %h want %h", d, 9'h00C | CAP);
        end
      end
    end
    vectors++;
    if (txout !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL disabled_idle: got %b want 1", txout);
    end
    n = rx_count;
    bus_write(A_CTRL, 8'h01);
    wait_drain(3000);
    vectors++;
    if (rx_count - n != 8 || sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL fifo_drain: got %0d frames, %0d pending want 8, 0", rx_count - n, sb.size());
    end
    bus_write(A_CTRL, 8'h00);
    bus_read(A_CTRL, d);
    vectors++;
    if (d !== (9'h002 | CAP)) begin
      miscompares++;
      $display("[TB] FAIL overrun_clear: got %h want %h", d, 9'h002 | CAP);
    end
  endtask

  task automatic test_txen_midframe();
    logic [8:0] d;
    int f, n;
    bit ok;
    bus_write(A_CTRL, 8'h01);
    sb.push_back(8'h5A);
    bus_write(A_TX, 8'h5A);
    bus_write(A_TX, 8'h33);
    wait_level(1'b0, 50, f, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL midframe_start: got no start want start bit");
    end
    while (cyc < f + 5 * bit_clks + 8) @(negedge clk);
    bus_write(A_CTRL, 8'h00);
    while (cyc < f + FRAME * bit_clks + 6) @(negedge clk);
    vectors++;
    if (txout !== 1'b1 || sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL midframe_complete: got txout=%b pending=%0d want 1, 0", txout, sb.size());
    end
    bus_read(A_CTRL, d);
    vectors++;
    if (d !== (9'h00A | CAP)) begin
      miscompares++;
      $display("[TB] FAIL midframe_retained: got %h want %h", d, 9'h00A | CAP);
    end
    n = rx_count;
    repeat (100) @(negedge clk);
    vectors++;
    if (txout !== 1'b1 || rx_count != n) begin
      miscompares++;
      $display("[TB] FAIL midframe_no_new: got txout=%b frames=%0d want 1, 0", txout, rx_count - n);
    end
  endtask

  task automatic test_reset_midframe();
    logic [8:0] d;
    int f;
    bit ok;
    rx_on = 1'b0;
    bus_write(A_CTRL, 8'h01);
    wait_level(1'b0, 50, f, ok);
    while (cyc < f + 3 * bit_clks + 5) @(negedge clk);
    vectors++;
    if (!ok || txout !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_low: got txout=%b seen=%0d want 0, 1", txout, ok);
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (txout !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL async_reset_txout: got %b want 1", txout);
    end
    @(negedge clk);
    reset = 1'b1;
    bit_clks = 432;
    bus_read(A_CTRL, d);
    vectors++;
    if (d !== (9'h002 | CAP)) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_ctrl: got %h want %h", d, 9'h002 | CAP);
    end
    bus_read(A_PERIOD, d);
    vectors++;
    if (d !== 9'h01A) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_period: got %h want 01a", d);
    end
    bus_write(A_CTRL, 8'h01);
    repeat (100) @(negedge clk);
    bus_read(A_CTRL, d);
    vectors++;
    if (txout !== 1'b1 || d !== (9'h003 | CAP)) begin
      miscompares++;
      $display("[TB] FAIL reset_fifo_lost: got txout=%b ctrl=%h want 1, %h", txout, d, 9'h003 | CAP);
    end
    bus_write(A_CTRL, 8'h00);
    rx_on = 1'b1;
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    bus_write(A_CTRL, 8'h01);
    sb.push_back(8'h07);
    bus_write(A_TX, 8'h07);
    wait_drain(6000);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL parity_frame: got %0d pending want 0", sb.size());
    end
    bus_write(A_CTRL, 8'h00);
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overrun();
    test_txen_midframe();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
